// File: rtl/noc_wormhole_switch_allocator.sv
// Two-stage separable switch allocator (input-first VC arbitration, then output arbitration)
// with wormhole output locking, downstream-ready masking and grant-qualified round-robin pointers.
`timescale 1ns/1ps
module noc_wormhole_switch_allocator #(
    parameter int PORT_CNT = 5,
    parameter int VC_NUM   = 4,
    parameter int PTR_W    = $clog2(PORT_CNT)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0]             request_in,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0][PTR_W-1:0]  out_sel_in,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0]             tail_in,
    input  logic [PORT_CNT-1:0]                         out_ready,
    output logic [PORT_CNT-1:0][VC_NUM-1:0]             grant_o,
    output logic [PORT_CNT-1:0]                         out_lock_o
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [PORT_CNT-1:0][VC_W-1:0]   r_vc_ptr;
    logic [PORT_CNT-1:0][PTR_W-1:0]  r_in_ptr;
    logic [PORT_CNT-1:0]             r_lock_vld;
    logic [PORT_CNT-1:0][PTR_W-1:0]  r_lock_port;
    logic [PORT_CNT-1:0][VC_W-1:0]   r_lock_vc;

    logic [PORT_CNT-1:0][VC_NUM-1:0] w_elig;
    logic [PORT_CNT-1:0]             w_s1_vld;
    logic [PORT_CNT-1:0][VC_W-1:0]   w_s1_vc;
    logic [PORT_CNT-1:0][PTR_W-1:0]  w_s1_tgt;
    logic [PORT_CNT-1:0]             w_s2_vld;
    logic [PORT_CNT-1:0][PTR_W-1:0]  w_s2_port;
    logic [PORT_CNT-1:0]             w_win;
    logic [PORT_CNT-1:0]             w_tail;

    // A locked output only accepts flits from its owning (input, VC).
    always_comb begin
        w_elig = '0;
        for (int p = 0; p < PORT_CNT; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_in[p][v] && (int'(out_sel_in[p][v]) < PORT_CNT)) begin
                    if (out_ready[out_sel_in[p][v]] &&
                        (!r_lock_vld[out_sel_in[p][v]] ||
                         ((r_lock_port[out_sel_in[p][v]] == PTR_W'(p)) &&
                          (r_lock_vc[out_sel_in[p][v]] == VC_W'(v))))) begin
                        w_elig[p][v] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        int              sum;
        logic [VC_W-1:0] vidx;
        sum      = 0;
        vidx     = '0;
        w_s1_vld = '0;
        w_s1_vc  = '0;
        w_s1_tgt = '0;
        for (int p = 0; p < PORT_CNT; p++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                sum = int'(r_vc_ptr[p]) + k;
                if (sum >= VC_NUM) sum = sum - VC_NUM;
                vidx = VC_W'(sum);
                if (!w_s1_vld[p] && w_elig[p][vidx]) begin
                    w_s1_vld[p] = 1'b1;
                    w_s1_vc[p]  = vidx;
                    w_s1_tgt[p] = out_sel_in[p][vidx];
                end
            end
        end
    end

    always_comb begin
        int               sum;
        logic [PTR_W-1:0] pidx;
        sum       = 0;
        pidx      = '0;
        w_s2_vld  = '0;
        w_s2_port = '0;
        w_win     = '0;
        for (int o = 0; o < PORT_CNT; o++) begin
            for (int k = 0; k < PORT_CNT; k++) begin
                sum = int'(r_in_ptr[o]) + k;
                if (sum >= PORT_CNT) sum = sum - PORT_CNT;
                pidx = PTR_W'(sum);
                if (!w_s2_vld[o] && w_s1_vld[pidx] && (w_s1_tgt[pidx] == PTR_W'(o))) begin
                    w_s2_vld[o]  = 1'b1;
                    w_s2_port[o] = pidx;
                    w_win[pidx]  = 1'b1;
                end
            end
        end
    end

    // Grants are suppressed while reset is held so the crossbar sees nothing during reset.
    always_comb begin
        grant_o = '0;
        w_tail  = '0;
        for (int p = 0; p < PORT_CNT; p++) begin
            if (w_win[p] && rst_n) grant_o[p][w_s1_vc[p]] = 1'b1;
        end
        for (int o = 0; o < PORT_CNT; o++) begin
            w_tail[o] = tail_in[w_s2_port[o]][w_s1_vc[w_s2_port[o]]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vc_ptr    <= '0;
            r_in_ptr    <= '0;
            r_lock_vld  <= '0;
            r_lock_port <= '0;
            r_lock_vc   <= '0;
        end else begin
            for (int p = 0; p < PORT_CNT; p++) begin
                if (w_win[p]) begin
                    r_vc_ptr[p] <= (w_s1_vc[p] == VC_W'(VC_NUM - 1)) ? '0 : w_s1_vc[p] + VC_W'(1);
                end
            end
            for (int o = 0; o < PORT_CNT; o++) begin
                if (w_s2_vld[o]) begin
                    r_in_ptr[o] <= (w_s2_port[o] == PTR_W'(PORT_CNT - 1)) ? '0 : w_s2_port[o] + PTR_W'(1);
                    if (w_tail[o]) begin
                        r_lock_vld[o] <= 1'b0;
                    end else begin
                        r_lock_vld[o]  <= 1'b1;
                        r_lock_port[o] <= w_s2_port[o];
                        r_lock_vc[o]   <= w_s1_vc[w_s2_port[o]];
                    end
                end
            end
        end
    end

    assign out_lock_o = r_lock_vld;

endmodule

// File: tb/tb_noc_wormhole_switch_allocator.sv
// Scoreboard bench for noc_wormhole_switch_allocator: a reference model predicts grants and
// locks per cycle, a separate monitor compares them against the DUT on the falling edge.
`timescale 1ns/1ps
module tb_noc_wormhole_switch_allocator;
    localparam int P = 5;
    localparam int V = 4;
    localparam int W = 3;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [P-1:0][V-1:0]        request_in;
    logic [P-1:0][V-1:0][W-1:0] out_sel_in;
    logic [P-1:0][V-1:0]        tail_in;
    logic [P-1:0]               out_ready;
    logic [P-1:0][V-1:0]        grant_o;
    logic [P-1:0]               out_lock_o;

    typedef struct packed {
        logic [P*V-1:0] grant;
        logic [P-1:0]   lock;
    } expT;

    expT expQ[$];
    int  errorCount = 0;
    int  checkCount = 0;

    int vcPtr[P];
    int inPtr[P];
    bit lockVld[P];
    int lockP[P];
    int lockV[P];
    int s1Vc[P];
    int s2Port[P];

    noc_wormhole_switch_allocator #(.PORT_CNT(P), .VC_NUM(V), .PTR_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request_in (request_in),
        .out_sel_in (out_sel_in),
        .tail_in    (tail_in),
        .out_ready  (out_ready),
        .grant_o    (grant_o),
        .out_lock_o (out_lock_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act !== req) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    function automatic void resetModel();
        for (int i = 0; i < P; i++) begin
            vcPtr[i] = 0; inPtr[i] = 0; lockVld[i] = 1'b0; lockP[i] = 0; lockV[i] = 0;
        end
    endfunction

    function automatic bit isEligible(int p, int v);
        int o;
        o = int'(out_sel_in[p][v]);
        if (!request_in[p][v]) return 1'b0;
        if (o >= P) return 1'b0;
        if (!out_ready[o]) return 1'b0;
        if (lockVld[o] && !(lockP[o] == p && lockV[o] == v)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [P*V-1:0] computeModel();
        logic [P*V-1:0] g;
        int v;
        int p;
        g = '0;
        for (int i = 0; i < P; i++) begin
            s1Vc[i] = -1;
            for (int k = 0; k < V; k++) begin
                v = (vcPtr[i] + k) % V;
                if (s1Vc[i] < 0 && isEligible(i, v)) s1Vc[i] = v;
            end
        end
        for (int o = 0; o < P; o++) begin
            s2Port[o] = -1;
            for (int k = 0; k < P; k++) begin
                p = (inPtr[o] + k) % P;
                if (s2Port[o] < 0 && s1Vc[p] >= 0 && int'(out_sel_in[p][s1Vc[p]]) == o) s2Port[o] = p;
            end
            if (s2Port[o] >= 0) g[s2Port[o]*V + s1Vc[s2Port[o]]] = 1'b1;
        end
        return g;
    endfunction

    function automatic void commitModel();
        int p;
        int v;
        for (int o = 0; o < P; o++) begin
            if (s2Port[o] >= 0) begin
                p = s2Port[o];
                v = s1Vc[p];
                vcPtr[p] = (v + 1) % V;
                inPtr[o] = (p + 1) % P;
                if (tail_in[p][v]) begin
                    lockVld[o] = 1'b0;
                end else begin
                    lockVld[o] = 1'b1; lockP[o] = p; lockV[o] = v;
                end
            end
        end
    endfunction

    // Called at posedge+1: predict this cycle, queue it, then advance the model at the edge.
    task automatic applyStimulus();
        expT e;
        if (!rst_n) resetModel();
        e.grant = rst_n ? computeModel() : '0;
        for (int o = 0; o < P; o++) e.lock[o] = lockVld[o];
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (rst_n) commitModel(); else resetModel();
    endtask

    task automatic clearInputs();
        request_in = '0;
        out_sel_in = '0;
        tail_in    = '0;
        out_ready  = '1;
    endtask

    task automatic setReq(input int p, input int v, input int o, input bit t);
        request_in[p][v] = 1'b1;
        out_sel_in[p][v] = W'(o);
        tail_in[p][v]    = t;
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("grant", 32'(grant_o), 32'(e.grant));
                checkOutput("outLock", 32'(out_lock_o), 32'(e.lock));
            end
        end
    end

    initial begin
        clearInputs();
        resetModel();
        @(posedge clk);
        #1;
        repeat (2) applyStimulus();
        rst_n = 1'b1;

        $display("[TB] pointer fairness");
        for (int v = 0; v < V; v++) setReq(0, v, 2, 1'b1);
        repeat (5) applyStimulus();

        $display("[TB] output contention");
        clearInputs();
        setReq(1, 2, 4, 1'b1);
        setReq(3, 0, 4, 1'b1);
        repeat (4) applyStimulus();

        $display("[TB] wormhole lock");
        clearInputs();
        setReq(2, 1, 0, 1'b0);
        applyStimulus();
        setReq(4, 3, 0, 1'b0);
        repeat (2) applyStimulus();
        tail_in[2][1] = 1'b1;
        applyStimulus();
        request_in[2][1] = 1'b0;
        applyStimulus();
        tail_in[4][3] = 1'b1;
        applyStimulus();

        $display("[TB] backpressure");
        clearInputs();
        setReq(2, 1, 0, 1'b0);
        applyStimulus();
        out_ready[0] = 1'b0;
        repeat (3) applyStimulus();
        out_ready[0] = 1'b1;
        tail_in[2][1] = 1'b1;
        applyStimulus();

        $display("[TB] invalid target");
        clearInputs();
        setReq(1, 0, 5, 1'b1);
        setReq(1, 1, 3, 1'b1);
        setReq(1, 2, 7, 1'b0);
        repeat (4) applyStimulus();

        $display("[TB] asynchronous reset mid-packet");
        clearInputs();
        setReq(0, 2, 3, 1'b0);
        repeat (2) applyStimulus();
        setReq(0, 0, 1, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetGrant", 32'(grant_o), 32'd0);
        checkOutput("asyncResetLock", 32'(out_lock_o), 32'd0);
        resetModel();
        @(posedge clk);
        #1;
        applyStimulus();
        rst_n = 1'b1;
        repeat (2) applyStimulus();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < P; p++) begin
                for (int v = 0; v < V; v++) begin
                    request_in[p][v] = 1'($urandom_range(0, 1));
                    out_sel_in[p][v] = W'($urandom_range(0, 6));
                    tail_in[p][v]    = 1'($urandom_range(0, 1));
                end
                out_ready[p] = ($urandom_range(0, 4) != 0);
            end
            applyStimulus();
        end

        clearInputs();
        repeat (3) @(negedge clk);
        checkOutput("queueDrain", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
